pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 32: width of one field in bits.
REQ-002 Parameter FIELDS, default 3: fields per entry (instr, npc, curr_pc order, field 0 in LSBs).
REQ-003 Parameter DEPTH, default 2: entry count; SHALL be a power of two, >= 2.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  upstream presents an entry.
REQ-007 in_ready  out  1  buffer can accept an entry this cycle.
REQ-008 in_data  in  FIELDS*DATA_W  entry payload.
REQ-009 out_valid  out  1  head entry available downstream.
REQ-010 out_ready  in  1  downstream consumes head this cycle.
REQ-011 out_data  out  FIELDS*DATA_W  head entry payload.
REQ-012 flush  in  1  discard all buffered entries.
REQ-013 freeze  in  1  hold all contents; no push, no pop.
REQ-014 count  out  $clog2(DEPTH+1)  current occupancy.
REQ-015 bubble_cnt  out  16  saturating count of downstream-starved cycles.

Function
REQ-016 Push fires when in_valid & in_ready; pop fires when out_valid & out_ready.
REQ-017 in_ready SHALL equal (count != DEPTH) & !freeze & !flush, combinationally.
REQ-018 out_valid SHALL equal (count != 0) & !freeze & !flush, combinationally.
REQ-019 out_data SHALL be the head entry when count != 0, else all zeros (bubble = zero instruction), regardless of freeze.
REQ-020 Latency: an entry pushed at edge N SHALL be visible on out_data/out_valid after edge N when buffer was empty (one-cycle latency, no combinational in-to-out bypass).
REQ-021 Simultaneous push and pop SHALL both occur; count unchanged; ordering preserved (FIFO).
REQ-022 When full, in_ready=0; a pop in that cycle SHALL NOT enable a same-cycle push.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; count range 0..DEPTH, never exceeded or underflowed.
REQ-024 flush SHALL, at the edge, set count=0 and both pointers to 0; any same-cycle push/pop is suppressed.
REQ-025 flush SHALL take priority over freeze; freeze over push/pop.
REQ-026 freeze SHALL hold pointers, count and storage unchanged; bubble_cnt also holds.
REQ-027 bubble_cnt SHALL increment by 1 each edge where out_ready=1, count=0, freeze=0, flush=0; saturate at 16'hFFFF.
REQ-028 bubble_cnt SHALL NOT be cleared by flush.
REQ-029 Storage contents are not cleared on pop/flush; only out_data masking (REQ-019) hides stale data.

Reset
REQ-030 RST=1 at an edge SHALL set count=0, pointers=0, bubble_cnt=0, overriding flush, freeze and handshakes.
REQ-031 During and after reset: out_valid=0, out_data=0, in_ready=1 once RST=0 and freeze=0.
REQ-032 Reset mid-operation SHALL discard all entries; no entry pushed before reset SHALL appear after it.

Verification
REQ-033 Reset, then push 0x11/0x22/0x33 fields with out_ready=0 -> count=1 next cycle, out_data={0x33,0x22,0x11}, out_valid=1.
REQ-034 DEPTH=2, push A,B,C back-to-back with out_ready=0 -> A,B accepted, in_ready=0 on C's cycle, count=2; then out_ready=1 -> A then B out, C accepted only after first pop edge.
REQ-035 count=1, push and pop same cycle for 10 cycles -> count stays 1, outputs in push order, pointers wrap without loss.
REQ-036 count=2 with freeze=1 and flush=1 same cycle -> next cycle count=0, out_valid=0, out_data=0.
REQ-037 freeze=1 for 5 cycles with in_valid=1, out_ready=1, count=1 -> no push/pop, count=1, bubble_cnt unchanged; release -> pop occurs.
REQ-038 Empty, out_ready=1 for 70000 cycles -> bubble_cnt saturates at 0xFFFF; RST=1 -> 0.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Small FIFO used as an elastic buffer between two pipeline stages. Each
//   entry holds FIELDS packed fields of DATA_W bits (instr, npc, curr_pc, with
//   field 0 in the LSBs). Pushes land in registered storage, so there is one
//   cycle of latency and no combinational path from input to output.
//
// Parameters
//   DATA_W  width of one field
//   FIELDS  fields per entry
//   DEPTH   number of entries; must be a power of two and at least 2
//
// Ports
//   CLK         sole clock, rising edge
//   RST         synchronous active-high reset
//   in_valid    upstream offers an entry
//   in_ready    buffer accepts an entry this cycle
//   in_data     entry payload
//   out_valid   head entry available downstream
//   out_ready   downstream consumes the head this cycle
//   out_data    head entry payload, zero when empty (bubble = zero instruction)
//   flush       discard all buffered entries
//   freeze      hold all state; no push, no pop
//   count       current occupancy 0..DEPTH
//   bubble_cnt  saturating count of cycles the consumer was starved
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int FIELDS = 3,
  parameter int DEPTH  = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FIELDS*DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIELDS*DATA_W-1:0]   out_data,
  input  logic                       flush,
  input  logic                       freeze,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                bubble_cnt
);

  localparam int EW = FIELDS * DATA_W;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [15:0]   bubble_q, bubble_d;

  logic push, pop, starved;

  // Handshake qualifiers already exclude flush and freeze, so push/pop below
  // never fire while the buffer is being held or cleared.
  assign in_ready  = (count_q != FULL) & ~freeze & ~flush;
  assign out_valid = (count_q != '0)   & ~freeze & ~flush;

  assign push    = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign starved = out_ready & (count_q == '0) & ~freeze & ~flush;

  // Stale storage is never cleared; masking here is what hides it.
  assign out_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

  assign count      = count_q;
  assign bubble_cnt = bubble_q;

  // Next-state: flush beats freeze beats push/pop. Pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    bubble_d = bubble_q;

    if (starved && bubble_q != 16'hFFFF) begin
      bubble_d = bubble_q + 16'd1;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (!freeze) begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bubble_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      bubble_q <= bubble_d;
    end
  end

  // Payload storage, not reset
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  localparam int DATA_W = 32;
  localparam int FIELDS = 3;
  localparam int DEPTH  = 2;
  localparam int EW     = DATA_W * FIELDS;
  localparam int CW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] out_data;
  logic          flush;
  logic          freeze;
  logic [CW-1:0] count;
  logic [15:0]   bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DATA_W), .FIELDS(FIELDS), .DEPTH(DEPTH)) dut (
    .CLK        (clk),
    .RST        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .flush      (flush),
    .freeze     (freeze),
    .count      (count),
    .bubble_cnt (bubble_cnt)
  );

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] ent(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {32'hC000_0000 + v, 32'hB000_0000 + v, 32'hA000_0000 + v};
  endfunction

  logic [EW-1:0] ea, eb, ec, ey, ez;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = 1'b0; freeze = 1'b0;
    step();
    step();
    chk("rst_count",  EW'(count),      EW'(0));
    chk("rst_valid",  EW'(out_valid),  EW'(0));
    chk("rst_data",   out_data,        '0);
    chk("rst_bubble", EW'(bubble_cnt), EW'(0));
    rst = 1'b0;
    #1;
    chk("rst_in_ready", EW'(in_ready), EW'(1));

    // single push, one-cycle latency
    in_valid = 1'b1;
    in_data  = {32'h33, 32'h22, 32'h11};
    step();
    in_valid = 1'b0;
    #1;
    chk("p1_count", EW'(count),     EW'(1));
    chk("p1_valid", EW'(out_valid), EW'(1));
    chk("p1_data",  out_data,       {32'h33, 32'h22, 32'h11});

    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("fl_count", EW'(count), EW'(0));
    chk("fl_data",  out_data,   '0);

    // fill to full, C blocked until first pop edge
    ea = ent(1); eb = ent(2); ec = ent(3);
    in_valid = 1'b1; in_data = ea;
    step();
    in_data = eb;
    step();
    in_data = ec;
    #1;
    chk("full_count",    EW'(count),    EW'(2));
    chk("full_in_ready", EW'(in_ready), EW'(0));
    out_ready = 1'b1;
    #1;
    chk("full_pop_no_push", EW'(in_ready), EW'(0));
    chk("head_a",           out_data,      ea);
    step();
    chk("after_pop_count", EW'(count),    EW'(1));
    chk("head_b",          out_data,      eb);
    chk("c_now_ready",     EW'(in_ready), EW'(1));
    step();
    chk("pushpop_count", EW'(count), EW'(1));
    chk("head_c",        out_data,   ec);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    #1;
    chk("drain_count",  EW'(count),      EW'(0));
    chk("drain_bubble", EW'(bubble_cnt), EW'(0));

    // steady push+pop at count=1, pointers wrap
    in_valid = 1'b1; in_data = ent(100);
    step();
    for (int i = 0; i < 10; i++) begin
      in_data = ent(101 + i);
      out_ready = 1'b1;
      #1;
      chk("stream_data", out_data, ent(100 + i));
      step();
      chk("stream_count", EW'(count), EW'(1));
    end
    chk("stream_last", out_data, ent(110));
    out_ready = 1'b0;
    in_data = ent(111);
    step();
    in_valid = 1'b0;
    #1;
    chk("two_count", EW'(count), EW'(2));

    // flush beats freeze
    freeze = 1'b1; flush = 1'b1;
    #1;
    chk("ff_in_ready",  EW'(in_ready),  EW'(0));
    chk("ff_out_valid", EW'(out_valid), EW'(0));
    chk("ff_data_held", out_data,       ent(110));
    step();
    freeze = 1'b0; flush = 1'b0;
    #1;
    chk("ff_count", EW'(count),     EW'(0));
    chk("ff_valid", EW'(out_valid), EW'(0));
    chk("ff_data",  out_data,       '0);

    // freeze holds everything
    ey = ent(200); ez = ent(201);
    in_valid = 1'b1; in_data = ey;
    step();
    in_data = ez; out_ready = 1'b1; freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("frz_in_ready",  EW'(in_ready),  EW'(0));
      chk("frz_out_valid", EW'(out_valid), EW'(0));
      step();
      chk("frz_count", EW'(count), EW'(1));
      chk("frz_data",  out_data,   ey);
    end
    chk("frz_bubble", EW'(bubble_cnt), EW'(0));
    freeze = 1'b0; in_valid = 1'b0;
    #1;
    chk("rel_valid", EW'(out_valid), EW'(1));
    step();
    out_ready = 1'b0;
    #1;
    chk("rel_count",  EW'(count),      EW'(0));
    chk("rel_bubble", EW'(bubble_cnt), EW'(0));

    // bubble counting: held by freeze, skipped on flush, not cleared by flush
    out_ready = 1'b1; freeze = 1'b1;
    step(); step(); step();
    chk("bub_frozen", EW'(bubble_cnt), EW'(0));
    freeze = 1'b0;
    step(); step(); step();
    chk("bub_three", EW'(bubble_cnt), EW'(3));
    flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("bub_flush", EW'(bubble_cnt), EW'(3));

    // reset mid-operation discards entries
    in_valid = 1'b1; in_data = ent(300);
    step();
    in_data = ent(301);
    step();
    chk("pre_rst_count", EW'(count), EW'(2));
    rst = 1'b1; in_data = ent(302); out_ready = 1'b1; freeze = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; freeze = 1'b0;
    #1;
    chk("mid_rst_count",  EW'(count),      EW'(0));
    chk("mid_rst_valid",  EW'(out_valid),  EW'(0));
    chk("mid_rst_data",   out_data,        '0);
    chk("mid_rst_bubble", EW'(bubble_cnt), EW'(0));
    chk("mid_rst_ready",  EW'(in_ready),   EW'(1));
    step();
    chk("post_rst_count", EW'(count), EW'(0));
    chk("post_rst_data",  out_data,   '0);

    // saturation
    out_ready = 1'b1;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    chk("sat_bubble", EW'(bubble_cnt), EW'(16'hFFFF));
    step();
    chk("sat_hold", EW'(bubble_cnt), EW'(16'hFFFF));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("sat_rst", EW'(bubble_cnt), EW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
